// File: rtl/scale_16to32b.sv
// Expander undoing the 32-to-16 scaler: rebuilds the full-width value by
// shifting the scaled input left SH bits per clock, exp_i times.
module scale_16to32b #(
  parameter int DW_IN   = 16,
  parameter int DW_OUT  = 32,
  parameter int SH      = 2,
  parameter int EW      = 4,
  parameter int EXP_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DW_IN-1:0]  data_i,
  input  logic [EW-1:0]     exp_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DW_OUT-1:0] y_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o,
  output logic              busy_o
);

  localparam logic [EW-1:0] EXP_LIM = EW'(EXP_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DW_OUT-1:0]   y_q, y_d;
  logic [EW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  // Holds ready_o low until the first edge after reset release
  logic                live_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (live_q && valid_i) begin
          if (exp_i > EXP_LIM) begin
            y_d     = '1;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            y_d   = DW_OUT'(data_i);
            ovf_d = 1'b0;
            if (exp_i == '0) begin
              state_d = DONE;
            end else begin
              cnt_d   = exp_i;
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        // Legal exponents never push a set bit past the top, so no guard here
        y_d   = y_q << SH;
        cnt_d = cnt_q - EW'(1);
        if (cnt_q == EW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = live_q && (state_q == IDLE);
  assign busy_o  = (state_q == SHIFT);
  assign valid_o = (state_q == DONE);
  assign y_o     = y_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_scale_16to32b.sv
// Directed self-checking bench for scale_16to32b; expected results are
// queued at accept time and matched when valid_o appears.
module tb_scale_16to32b;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] data_i;
  logic [3:0]  exp_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] y_o;
  logic        valid_o;
  logic        ready_i;
  logic        ovf_o;
  logic        busy_o;

  typedef struct {
    logic [15:0] d;
    logic [31:0] y;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  scale_16to32b dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .exp_i   (exp_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .y_o     (y_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Independent reference: one bulk shift of the zero-extended input
  function automatic exp_t model(input logic [15:0] d, input logic [3:0] e);
    exp_t r;
    logic [31:0] w;
    r.d = d;
    if (e > 4'd8) begin
      r.y = 32'hFFFF_FFFF; r.ovf = 1'b1; r.lat = 0;
    end else begin
      w = {16'h0000, d};
      w = w << (2 * e);
      r.y = w; r.ovf = 1'b0; r.lat = int'(e);
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] e);
    check("ready_before_accept", {31'b0, ready_o}, 32'd1);
    sb.push_back(model(d, e));
    data_i  = d;
    exp_i   = e;
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    exp_i   = 4'hF;
    data_i  = 16'hDEAD;
  endtask

  task automatic checkOutput(input bit steps);
    exp_t e;
    int   lat;
    logic [31:0] mid;
    e = sb[0];
    lat = 0;
    while (!valid_o && lat < 20) begin
      if (steps) begin
        mid = {16'h0000, e.d};
        mid = mid << (2 * lat);
        check("shift_step", y_o, mid);
        check("busy_step", {31'b0, busy_o}, 32'd1);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
    end
    check("valid_seen", {31'b0, valid_o}, 32'd1);
    void'(sb.pop_front());
    check("y", y_o, e.y);
    check("ovf", {31'b0, ovf_o}, {31'b0, e.ovf});
    check("latency", lat, e.lat);
    check("busy_done", {31'b0, busy_o}, 32'd0);
    if (ready_i) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("valid_one_cycle", {31'b0, valid_o}, 32'd0);
      check("ready_back", {31'b0, ready_o}, 32'd1);
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0; exp_i = '0;

    #23 rst_i = 1'b0;
    #1;
    check("rst_y", y_o, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_ovf", {31'b0, ovf_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check("ready_pre_edge", {31'b0, ready_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("ready_post_edge", {31'b0, ready_o}, 32'd1);

    $display("[TB] zero exponent and normal expand");
    ready_i = 1'b1;
    applyStimulus(16'h1234, 4'd0); checkOutput(1'b1);
    applyStimulus(16'hABCD, 4'd3); checkOutput(1'b1);
    applyStimulus(16'hFFFF, 4'd8); checkOutput(1'b1);
    applyStimulus(16'hFFFF, 4'd9); checkOutput(1'b0);
    applyStimulus(16'h0000, 4'd5); checkOutput(1'b1);
    applyStimulus(16'h5555, 4'd15); checkOutput(1'b0);
    applyStimulus(16'h8001, 4'd1); checkOutput(1'b1);

    $display("[TB] backpressure");
    ready_i = 1'b0;
    applyStimulus(16'hBEEF, 4'd2); checkOutput(1'b0);
    valid_i = 1'b1; data_i = 16'h1111; exp_i = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("hold_y", y_o, 32'h000B_EEF0);
      check("hold_valid", {31'b0, valid_o}, 32'd1);
      check("hold_ready", {31'b0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("release_valid", {31'b0, valid_o}, 32'd0);
    check("release_ready", {31'b0, ready_o}, 32'd1);
    check("release_y_kept", y_o, 32'h000B_EEF0);
    applyStimulus(16'h0001, 4'd1); checkOutput(1'b1);

    $display("[TB] reset mid-shift");
    applyStimulus(16'h00FF, 4'd6);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_busy", {31'b0, busy_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    sb.delete();
    check("abort_y", y_o, 32'd0);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_valid", {31'b0, valid_o}, 32'd0);
    check("abort_ready", {31'b0, ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("after_abort_ready", {31'b0, ready_o}, 32'd1);
    check("after_abort_valid", {31'b0, valid_o}, 32'd0);

    $display("[TB] round trip");
    applyStimulus(16'h1234, 4'd8); checkOutput(1'b0);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
